nyq_seq_ctrl: RTL and testbench

Phase sequencer for the NYQ block. It accepts a frame configuration, then on Start drives a down-counting phase index (last..0, wrap) for a programmed number of frames. It emits per-phase valid, a frame-done pulse at each wrap, and a done pulse at the end of the run. It sits between the block-level control interface and the NYQ datapath, which consumes Phase_DO as its sample/slot select.

---
 rtl/nyq_pkg.sv | 18 +
 rtl/nyq_seq_ctrl_if.sv | 27 ++
 rtl/nyq_phase_cnt.sv | 33 +++
 rtl/nyq_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_nyq_seq_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/nyq_pkg.sv
// NYQ phase sequencer shared types.
// State encoding and width defaults.
package nyq_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int FRM_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] PHASE_RST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/nyq_seq_ctrl_if.sv
// NYQ sequencer configuration handshake.
// Master offers a frame config, slave accepts.
interface nyq_seq_ctrl_if #(
  parameter int CNT_W = 3,
  parameter int FRM_W = 8
);

  logic             Cfg_Valid_SI;
  logic             Cfg_Ready_SO;
  logic [CNT_W-1:0] Cfg_Last_DI;
  logic [FRM_W-1:0] Cfg_Frames_DI;

  modport master (
    output Cfg_Valid_SI,
    output Cfg_Last_DI,
    output Cfg_Frames_DI,
    input  Cfg_Ready_SO
  );

  modport slave (
    input  Cfg_Valid_SI,
    input  Cfg_Last_DI,
    input  Cfg_Frames_DI,
    output Cfg_Ready_SO
  );

endinterface

// File: rtl/nyq_phase_cnt.sv
// Loadable phase down-counter.
// Resets to all ones; load wins over enable.
module nyq_phase_cnt
  import nyq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Load_SI,
  input  logic             Enable_SI,
  input  logic [CNT_W-1:0] Load_DI,
  output logic [CNT_W-1:0] Cnt_DO,
  output logic             Zero_SO
);

  logic [CNT_W-1:0] cnt_q;

  // Phase register: load, decrement or hold.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      cnt_q <= '1;
    end else if (Load_SI) begin
      cnt_q <= Load_DI;
    end else if (Enable_SI) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign Cnt_DO  = cnt_q;
  assign Zero_SO = (cnt_q == '0);

endmodule

// File: rtl/nyq_seq_ctrl.sv
// NYQ phase sequencer: config, run, drain, done.
// Drives phase index and frame/run pulses.
module nyq_seq_ctrl
  import nyq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FRM_W = FRM_W_DEF
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  nyq_seq_ctrl_if.slave    Cfg,
  input  logic             Start_SI,
  input  logic             Stop_SI,
  output logic [CNT_W-1:0] Phase_DO,
  output logic             Phase_Valid_SO,
  output logic             Frame_Done_SO,
  output logic             Done_SO,
  output logic             Busy_SO
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic [FRM_W-1:0] left_q, left_d;
  logic             valid_d, fd_d, done_d, busy_d;
  logic             ld, en, zero;
  logic [CNT_W-1:0] ld_val, phase_nxt;

  nyq_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clk_CI    (Clk_CI),
    .Rst_RBI   (Rst_RBI),
    .Load_SI   (ld),
    .Enable_SI (en),
    .Load_DI   (ld_val),
    .Cnt_DO    (Phase_DO),
    .Zero_SO   (zero)
  );

  assign Cfg.Cfg_Ready_SO = (state_q == S_IDLE);

  // State, latched config and registered outputs.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q        <= S_IDLE;
      last_q         <= '1;
      frames_q       <= '0;
      left_q         <= '0;
      Phase_Valid_SO <= 1'b0;
      Frame_Done_SO  <= 1'b0;
      Done_SO        <= 1'b0;
      Busy_SO        <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      frames_q       <= frames_d;
      left_q         <= left_d;
      Phase_Valid_SO <= valid_d;
      Frame_Done_SO  <= fd_d;
      Done_SO        <= done_d;
      Busy_SO        <= busy_d;
    end
  end

  // Next state, counter control and next outputs.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    frames_d = frames_q;
    left_d   = left_q;
    ld       = 1'b0;
    en       = 1'b0;
    ld_val   = last_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Cfg.Cfg_Valid_SI) begin
          last_d   = Cfg.Cfg_Last_DI;
          frames_d = Cfg.Cfg_Frames_DI;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        if (Stop_SI) begin
          state_d = S_IDLE;
        end else if (Start_SI) begin
          state_d = S_RUN;
          ld      = 1'b1;
          left_d  = frames_q;
          valid_d = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        valid_d = 1'b1;
        if (zero) begin
          ld = 1'b1;
          if (left_q != '0) begin
            left_d = left_q - 1'b1;
          end
          // Wrap ends the run on drain, stop or final frame.
          if (state_q == S_DRAIN || Stop_SI ||
              left_q == FRM_W'(1)) begin
            state_d = S_DONE;
            ld_val  = '1;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          en = 1'b1;
          if (state_q == S_RUN && Stop_SI) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DONE: begin
        state_d = S_ARMED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    phase_nxt = ld ? ld_val : (en ? Phase_DO - 1'b1 : Phase_DO);
    fd_d      = valid_d && (phase_nxt == '0);
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

endmodule

// File: tb/tb_nyq_seq_ctrl.sv
// Self-checking bench for nyq_seq_ctrl.
// Scenario table plus hand-written corner sequences.
module tb_nyq_seq_ctrl;

  logic       Clk_CI = 1'b0;
  logic       Rst_RBI;
  logic       Start_SI;
  logic       Stop_SI;
  logic [2:0] Phase_DO;
  logic       Phase_Valid_SO;
  logic       Frame_Done_SO;
  logic       Done_SO;
  logic       Busy_SO;

  int checks = 0;
  int errors = 0;

  always #5 Clk_CI = ~Clk_CI;

  nyq_seq_ctrl_if #(.CNT_W(3), .FRM_W(8)) cfg_if ();

  nyq_seq_ctrl #(
    .CNT_W (3),
    .FRM_W (8)
  ) dut (
    .Clk_CI         (Clk_CI),
    .Rst_RBI        (Rst_RBI),
    .Cfg            (cfg_if),
    .Start_SI       (Start_SI),
    .Stop_SI        (Stop_SI),
    .Phase_DO       (Phase_DO),
    .Phase_Valid_SO (Phase_Valid_SO),
    .Frame_Done_SO  (Frame_Done_SO),
    .Done_SO        (Done_SO),
    .Busy_SO        (Busy_SO)
  );

  typedef struct {
    int last;
    int frames;
    int stop_at;
    int exp_nv;
    int exp_nfd;
  } vec_t;

  typedef struct {
    int phase;
    int fd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic do_cfg(input int last, input int frames);
    chk("cfg_ready_idle", 32'(cfg_if.Cfg_Ready_SO), 1);
    cfg_if.Cfg_Valid_SI  = 1'b1;
    cfg_if.Cfg_Last_DI   = 3'(last);
    cfg_if.Cfg_Frames_DI = 8'(frames);
    step();
    cfg_if.Cfg_Valid_SI  = 1'b0;
    chk("cfg_ready_armed", 32'(cfg_if.Cfg_Ready_SO), 0);
  endtask

  task automatic run(input int last, input int frames,
                     input int stop_at,
                     output int nv, output int nfd);
    int flen;
    int n;
    exp_t e;
    flen = last + 1;
    n = (frames == 0) ? 4096 : frames * flen;
    if (stop_at >= 0 && (stop_at / flen + 1) * flen < n)
      n = (stop_at / flen + 1) * flen;
    for (int c = 0; c < n; c++) begin
      e.phase = last - (c % flen);
      e.fd    = ((c % flen) == last) ? 1 : 0;
      sb.push_back(e);
    end
    Start_SI = 1'b1;
    step();
    Start_SI = 1'b0;
    nv  = 0;
    nfd = 0;
    for (int c = 0; c < n; c++) begin
      e = sb.pop_front();
      chk("run_valid", 32'(Phase_Valid_SO), 1);
      chk("run_phase", 32'(Phase_DO), 32'(e.phase));
      chk("run_frame_done", 32'(Frame_Done_SO), 32'(e.fd));
      chk("run_busy", 32'(Busy_SO), 1);
      chk("run_done_early", 32'(Done_SO), 0);
      nv  += int'(Phase_Valid_SO);
      nfd += int'(Frame_Done_SO);
      Stop_SI = (c == stop_at);
      step();
    end
    Stop_SI = 1'b0;
    chk("end_done", 32'(Done_SO), 1);
    chk("end_valid", 32'(Phase_Valid_SO), 0);
    chk("end_phase", 32'(Phase_DO), 7);
    chk("end_busy", 32'(Busy_SO), 0);
    chk("end_frame_done", 32'(Frame_Done_SO), 0);
    step();
    chk("post_done", 32'(Done_SO), 0);
    chk("post_armed_ready", 32'(cfg_if.Cfg_Ready_SO), 0);
    chk("post_valid", 32'(Phase_Valid_SO), 0);
  endtask

  task automatic to_idle();
    Stop_SI = 1'b1;
    step();
    Stop_SI = 1'b0;
    chk("back_idle_ready", 32'(cfg_if.Cfg_Ready_SO), 1);
  endtask

  initial begin
    int nv;
    int nfd;
    vecs[0] = '{last: 7, frames: 2, stop_at: -1, exp_nv: 16, exp_nfd: 2};
    vecs[1] = '{last: 3, frames: 0, stop_at: 9, exp_nv: 12, exp_nfd: 3};
    vecs[2] = '{last: 0, frames: 5, stop_at: -1, exp_nv: 5, exp_nfd: 5};
    vecs[3] = '{last: 2, frames: 0, stop_at: 5, exp_nv: 6, exp_nfd: 2};
    vecs[4] = '{last: 4, frames: 1, stop_at: 0, exp_nv: 5, exp_nfd: 1};
    vecs[5] = '{last: 1, frames: 3, stop_at: -1, exp_nv: 6, exp_nfd: 3};

    Rst_RBI              = 1'b0;
    Start_SI             = 1'b0;
    Stop_SI              = 1'b0;
    cfg_if.Cfg_Valid_SI  = 1'b0;
    cfg_if.Cfg_Last_DI   = '0;
    cfg_if.Cfg_Frames_DI = '0;
    step();
    step();
    Rst_RBI = 1'b1;
    chk("rst_phase", 32'(Phase_DO), 7);
    chk("rst_valid", 32'(Phase_Valid_SO), 0);
    chk("rst_frame_done", 32'(Frame_Done_SO), 0);
    chk("rst_done", 32'(Done_SO), 0);
    chk("rst_busy", 32'(Busy_SO), 0);
    chk("rst_ready", 32'(cfg_if.Cfg_Ready_SO), 1);

    Start_SI = 1'b1;
    step();
    Start_SI = 1'b0;
    chk("idle_start_valid", 32'(Phase_Valid_SO), 0);
    chk("idle_start_ready", 32'(cfg_if.Cfg_Ready_SO), 1);

    for (int i = 0; i < 6; i++) begin
      do_cfg(vecs[i].last, vecs[i].frames);
      run(vecs[i].last, vecs[i].frames, vecs[i].stop_at, nv, nfd);
      chk("tbl_valid_cycles", 32'(nv), 32'(vecs[i].exp_nv));
      chk("tbl_frame_dones", 32'(nfd), 32'(vecs[i].exp_nfd));
      to_idle();
    end

    do_cfg(2, 1);
    run(2, 1, -1, nv, nfd);
    run(2, 1, -1, nv, nfd);
    chk("rerun_valid_cycles", 32'(nv), 3);
    to_idle();

    do_cfg(3, 0);
    Start_SI = 1'b1;
    Stop_SI  = 1'b1;
    step();
    Start_SI = 1'b0;
    Stop_SI  = 1'b0;
    chk("startstop_ready", 32'(cfg_if.Cfg_Ready_SO), 1);
    for (int c = 0; c < 3; c++) begin
      chk("startstop_valid", 32'(Phase_Valid_SO), 0);
      chk("startstop_busy", 32'(Busy_SO), 0);
      step();
    end

    do_cfg(7, 0);
    Start_SI = 1'b1;
    step();
    Start_SI = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("prerst_phase", 32'(Phase_DO), 32'(7 - c));
      step();
    end
    chk("prerst_phase4", 32'(Phase_DO), 4);
    Rst_RBI = 1'b0;
    step();
    Rst_RBI = 1'b1;
    chk("midrst_phase", 32'(Phase_DO), 7);
    chk("midrst_valid", 32'(Phase_Valid_SO), 0);
    chk("midrst_busy", 32'(Busy_SO), 0);
    chk("midrst_done", 32'(Done_SO), 0);
    chk("midrst_ready", 32'(cfg_if.Cfg_Ready_SO), 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("postrst_done", 32'(Done_SO), 0);
      chk("postrst_valid", 32'(Phase_Valid_SO), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
